aes_share_loader: RTL and testbench

- Upstream feeder for the byte-serial two-share masked AES Cipher core.
- Accepts a full 128-bit plaintext and 128-bit key over a valid/ready handshake.
- Splits each byte into two Boolean shares using fresh randomness and streams 16 byte pairs into the core, driving the core's reset and FreshRandom.
- Then waits for the core's Done, with a timeout guard, before accepting the next block.

---
 rtl/aes_share_loader.sv | 203 ++++++++++++++++++++
 tb/tb_aes_share_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_share_loader.sv
// aes_share_loader: feeds a byte-serial two-share masked AES core.
// Accepts a 128-bit plaintext/key block, streams 16 Boolean-masked byte
// pairs into the core, then waits (with a timeout guard) for Done.
// Optional build macro SHARE_LOADER_LFSR_EN: masks come from an internal
// 31-bit LFSR seeded at accept instead of directly from rnd_in.
module aes_share_loader #(
    parameter int NBYTES       = 16,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    input  logic [16:0]  rnd_in,
    output logic         cipher_rst,
    output logic [7:0]   input1,
    output logic [7:0]   input2,
    output logic [7:0]   key1,
    output logic [7:0]   key2,
    output logic         FreshRandom,
    input  logic         cipher_done,
    output logic         busy,
    output logic         timeout
);

    localparam int          WW       = $clog2(DONE_TIMEOUT + 1);
    localparam logic [3:0]  LAST_CNT = 4'(NBYTES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic [127:0]  pt_reg, pt_next;
    logic [127:0]  key_reg, key_next;
    logic [7:0]    input1_reg, input1_next;
    logic [7:0]    input2_reg, input2_next;
    logic [7:0]    key1_reg, key1_next;
    logic [7:0]    key2_reg, key2_next;
    logic          fresh_reg, fresh_next;
    logic          crst_reg, crst_next;
    logic          busy_reg, busy_next;
    logic          ready_reg, ready_next;
    logic          timeout_reg, timeout_next;
    logic [16:0]   mask;

`ifdef SHARE_LOADER_LFSR_EN
    logic [30:0] lfsr_reg, lfsr_next, lfsr_adv;

    // Seventeen Fibonacci steps of x^31 + x^28 + 1 per clock.
    function automatic logic [30:0] lfsr_step17(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        for (int i = 0; i < 17; i++) begin
            t = {t[29:0], t[30] ^ t[27]};
        end
        return t;
    endfunction

    // Masks are taken from the freshly advanced LFSR word.
    always_comb begin
        lfsr_adv = lfsr_step17(lfsr_reg);
        mask     = lfsr_adv[16:0];
    end
`else
    // Masks come straight from the external randomness each cycle.
    always_comb begin
        mask = rnd_in;
    end
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wait_next    = wait_reg;
        pt_next      = pt_reg;
        key_next     = key_reg;
        input1_next  = 8'h00;
        input2_next  = 8'h00;
        key1_next    = 8'h00;
        key2_next    = 8'h00;
        fresh_next   = 1'b0;
        crst_next    = 1'b1;
        timeout_next = timeout_reg;
`ifdef SHARE_LOADER_LFSR_EN
        lfsr_next    = lfsr_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (in_valid && ready_reg) begin
                    pt_next    = plaintext;
                    key_next   = key;
                    cnt_next   = 4'd0;
                    state_next = S_LOAD;
`ifdef SHARE_LOADER_LFSR_EN
                    lfsr_next  = {14'h1, rnd_in};
`endif
                end
            end
            S_LOAD: begin
`ifdef SHARE_LOADER_LFSR_EN
                lfsr_next   = lfsr_adv;
`endif
                input2_next = mask[7:0];
                input1_next = pt_reg[127:120] ^ mask[7:0];
                key2_next   = mask[15:8];
                key1_next   = key_reg[127:120] ^ mask[15:8];
                fresh_next  = mask[16];
                // Byte 0 overlaps the core's final reset cycle.
                crst_next   = (cnt_reg == 4'd0);
                // Shift so the next byte is always at the top; the plain
                // data drains out of the registers as it is consumed.
                pt_next     = {pt_reg[119:0], 8'h00};
                key_next    = {key_reg[119:0], 8'h00};
                if (cnt_reg == LAST_CNT) begin
                    state_next = S_WAIT;
                    wait_next  = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_WAIT: begin
`ifdef SHARE_LOADER_LFSR_EN
                lfsr_next  = lfsr_adv;
`endif
                crst_next  = 1'b0;
                fresh_next = mask[16];
                wait_next  = wait_reg + 1'b1;
                if (cipher_done) begin
                    state_next = S_IDLE;
                    crst_next  = 1'b1;
                    fresh_next = 1'b0;
                end else if (wait_reg == WAIT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = S_IDLE;
                    crst_next    = 1'b1;
                    fresh_next   = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy_next  = (state_next != S_IDLE);
        ready_next = (state_next == S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 4'd0;
            wait_reg    <= '0;
            pt_reg      <= '0;
            key_reg     <= '0;
            input1_reg  <= 8'h00;
            input2_reg  <= 8'h00;
            key1_reg    <= 8'h00;
            key2_reg    <= 8'h00;
            fresh_reg   <= 1'b0;
            crst_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            timeout_reg <= 1'b0;
`ifdef SHARE_LOADER_LFSR_EN
            lfsr_reg    <= 31'h1;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wait_reg    <= wait_next;
            pt_reg      <= pt_next;
            key_reg     <= key_next;
            input1_reg  <= input1_next;
            input2_reg  <= input2_next;
            key1_reg    <= key1_next;
            key2_reg    <= key2_next;
            fresh_reg   <= fresh_next;
            crst_reg    <= crst_next;
            busy_reg    <= busy_next;
            ready_reg   <= ready_next;
            timeout_reg <= timeout_next;
`ifdef SHARE_LOADER_LFSR_EN
            lfsr_reg    <= lfsr_next;
`endif
        end
    end

    assign in_ready    = ready_reg;
    assign cipher_rst  = crst_reg;
    assign input1      = input1_reg;
    assign input2      = input2_reg;
    assign key1        = key1_reg;
    assign key2        = key2_reg;
    assign FreshRandom = fresh_reg;
    assign busy        = busy_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_aes_share_loader.sv
// Self-checking bench for aes_share_loader: table of blocks with a
// behavioural model (byte extraction, XOR of shares, WAIT exit timing),
// plus an asynchronous mid-load reset sequence.
module tb_aes_share_loader;

    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [16:0]  rnd_in;
    logic         cipher_rst;
    logic [7:0]   input1, input2, key1, key2;
    logic         FreshRandom;
    logic         cipher_done;
    logic         busy;
    logic         timeout;

    int   errors = 0;
    int   checks = 0;
    logic exp_timeout = 1'b0;

    aes_share_loader #(.NBYTES(16), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .rnd_in(rnd_in),
        .cipher_rst(cipher_rst), .input1(input1), .input2(input2),
        .key1(key1), .key2(key2), .FreshRandom(FreshRandom),
        .cipher_done(cipher_done), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        bit           rand_mask;
        logic [16:0]  cmask;
        int           done_delay;   // WAIT cycle index of Done pulse, -1 = never
        logic [7:0]   exp_in1_b0;   // expected input1 for byte 0 (constant masks)
        logic [7:0]   exp_key1_b0;  // expected key1 for byte 0 (constant masks)
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte k of a 128-bit word, byte 0 being the most significant.
    function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
        logic [127:0] s;
        s = v >> (8 * (15 - k));
        return s[7:0];
    endfunction

    task automatic do_block(input vec_t v, input int abort_at);
        logic [16:0] r;
        logic [15:0] masks [$];
        int          exit_c;
        logic        to_now;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_cipher_rst", cipher_rst, 1);
        in_valid    = 1'b1;
        plaintext   = v.pt;
        key         = v.key;
        rnd_in      = v.rand_mask ? 17'($urandom) : v.cmask;
        cipher_done = 1'b0;
        @(negedge clk);
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
        chk("accept_shares_zero", {input1, input2, key1, key2}, 0);
        chk("accept_cipher_rst", cipher_rst, 1);
        for (int k = 0; k < 16; k++) begin
            r           = v.rand_mask ? 17'($urandom) : v.cmask;
            rnd_in      = r;
            in_valid    = 1'($urandom);
            plaintext   = {$urandom, $urandom, $urandom, $urandom};
            key         = {$urandom, $urandom, $urandom, $urandom};
            cipher_done = 1'($urandom);
            @(negedge clk);
            chk($sformatf("data_xor_b%0d", k), input1 ^ input2, byte_of(v.pt, k));
            chk($sformatf("key_xor_b%0d", k), key1 ^ key2, byte_of(v.key, k));
            chk($sformatf("load_cipher_rst_b%0d", k), cipher_rst, (k == 0));
            chk($sformatf("load_busy_b%0d", k), busy, 1);
`ifdef SHARE_LOADER_LFSR_EN
            masks.push_back({key2, input2});
`else
            chk($sformatf("input2_b%0d", k), input2, r[7:0]);
            chk($sformatf("key2_b%0d", k), key2, r[15:8]);
            chk($sformatf("fresh_b%0d", k), FreshRandom, r[16]);
            if (!v.rand_mask && k == 0) begin
                chk("input1_b0", input1, v.exp_in1_b0);
                chk("key1_b0", key1, v.exp_key1_b0);
            end
`endif
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("arst_shares", {input1, input2, key1, key2}, 0);
                chk("arst_cipher_rst", cipher_rst, 1);
                chk("arst_busy", busy, 0);
                chk("arst_in_ready", in_ready, 1);
                chk("arst_timeout", timeout, 0);
                chk("arst_fresh", FreshRandom, 0);
                exp_timeout = 1'b0;
                in_valid    = 1'b0;
                cipher_done = 1'b0;
                rst         = 1'b0;
                @(negedge clk);
                return;
            end
        end
        in_valid  = 1'b0;
        plaintext = '0;
        key       = '0;
`ifdef SHARE_LOADER_LFSR_EN
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("lfsr_mask_nonzero_b%0d", i), (masks[i] != 16'h0), 1);
            for (int j = i + 1; j < 16; j++)
                chk($sformatf("lfsr_mask_distinct_%0d_%0d", i, j), (masks[i] != masks[j]), 1);
        end
`endif
        to_now = !(v.done_delay >= 0 && v.done_delay <= TO - 1);
        exit_c = to_now ? TO - 1 : v.done_delay;
        for (int c = 0; c <= exit_c; c++) begin
            cipher_done = (c == v.done_delay);
            r           = 17'($urandom);
            rnd_in      = r;
            @(negedge clk);
            if (c < exit_c) begin
                chk("wait_shares_zero", {input1, input2, key1, key2}, 0);
                chk("wait_cipher_rst", cipher_rst, 0);
                chk("wait_busy", busy, 1);
                chk("wait_timeout", timeout, exp_timeout);
`ifndef SHARE_LOADER_LFSR_EN
                chk("wait_fresh", FreshRandom, r[16]);
`endif
            end else begin
                exp_timeout = exp_timeout | to_now;
                chk("exit_in_ready", in_ready, 1);
                chk("exit_busy", busy, 0);
                chk("exit_cipher_rst", cipher_rst, 1);
                chk("exit_timeout", timeout, exp_timeout);
                chk("exit_fresh", FreshRandom, 0);
                chk("exit_shares_zero", {input1, input2, key1, key2}, 0);
            end
        end
        cipher_done = 1'b0;
        $display("block pt=%h done_delay=%0d timeout=%b checks=%0d errors=%0d",
                 v.pt, v.done_delay, timeout, checks, errors);
    endtask

    // Hard stop in case the run ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vr;
        tbl[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   1'b0, 17'h00000, 200, 8'h32, 8'h2b};
        tbl[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   1'b1, 17'h00000, 0, 8'h00, 8'h00};
        tbl[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                   1'b0, 17'h1A55A, TO - 1, 8'h5A, 8'hA5};
        tbl[3] = '{128'hffffffffffffffffffffffffffffffff, 128'h00000000000000000000000000000000,
                   1'b1, 17'h00000, -1, 8'h00, 8'h00};
        tbl[4] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   1'b0, 17'h0FFFF, 5, 8'hCD, 8'hD4};

        rst         = 1'b1;
        in_valid    = 1'b0;
        plaintext   = '0;
        key         = '0;
        rnd_in      = '0;
        cipher_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_shares", {input1, input2, key1, key2}, 0);
        chk("reset_cipher_rst", cipher_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_timeout", timeout, 0);
        chk("reset_fresh", FreshRandom, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) do_block(tbl[i], -1);

        // Asynchronous reset while byte 7 is presented, then a clean block.
        vr = tbl[1];
        vr.done_delay = 3;
        do_block(vr, 7);
        do_block(tbl[4], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
